// File: rtl/uart_frame_decoder_if.sv
// Byte-stream link from the UART receive source into the frame decoder.
// The UART side is the master; the decoder samples data only while valid is high.
interface uart_frame_decoder_if;
  logic [7:0] data;
  logic       valid;

  modport master (output data, output valid);
  modport slave  (input  data, input  valid);
endinterface

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC/CMD/LEN/payload/CHK frames from the UART byte stream and
// commits them into the transmitter control registers.
module uart_frame_decoder #(
  parameter int          TIMEOUT_CYCLES    = 25000,
  parameter logic [31:0] DEFAULT_PATTERN   = 32'hA5A5_A5A5,
  parameter logic [31:0] DEFAULT_MAX_COUNT = 32'd9_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  uart_frame_decoder_if.slave        from_uart,
  output logic [31:0]                pattern_data,
  output logic                       pattern_update,
  output logic [31:0]                max_count,
  output logic                       count_update,
  output logic                       tx_enable,
  output logic                       frame_ok,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic [7:0]                 err_count
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] LEN     = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] CHK     = 3'd4;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]    state_reg, state_next;
  logic [7:0]    cmd_reg, cmd_next;
  logic [3:0]    len_reg, len_next;
  logic [3:0]    byte_cnt_reg, byte_cnt_next;
  logic [7:0]    xor_reg, xor_next;
  // Only the last four payload bytes can ever be committed, so older bytes fall off.
  logic [31:0]   shift_reg, shift_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  logic [31:0] pattern_reg, max_count_reg;
  logic        pattern_update_reg, count_update_reg, tx_enable_reg;
  logic        frame_ok_reg, frame_err_reg;
  logic [1:0]  err_code_reg;
  logic [7:0]  err_count_reg;

  logic       commit, reject, cmd_ok;
  logic [1:0] reject_code;
  logic [3:0] cnt_inc;

  assign cmd_ok  = ((cmd_reg == 8'h01 || cmd_reg == 8'h02) && len_reg == 4'd4) ||
                   (cmd_reg == 8'h03 && len_reg == 4'd1);
  assign cnt_inc = byte_cnt_reg + 4'd1;

  always_comb begin
    state_next    = state_reg;
    cmd_next      = cmd_reg;
    len_next      = len_reg;
    byte_cnt_next = byte_cnt_reg;
    xor_next      = xor_reg;
    shift_next    = shift_reg;
    timeout_next  = '0;
    commit        = 1'b0;
    reject        = 1'b0;
    reject_code   = 2'd0;

    // A byte arriving in the same cycle as expiry wins over the timeout.
    if (state_reg != IDLE) begin
      if (from_uart.valid) begin
        timeout_next = '0;
      end else if (timeout_reg == TW'(TIMEOUT_CYCLES)) begin
        reject      = 1'b1;
        reject_code = 2'd3;
        state_next  = IDLE;
      end else begin
        timeout_next = timeout_reg + 1'b1;
      end
    end

    if (from_uart.valid) begin
      case (state_reg)
        IDLE: begin
          if (from_uart.data == 8'hA5) state_next = CMD;
        end
        CMD: begin
          cmd_next   = from_uart.data;
          xor_next   = from_uart.data;
          state_next = LEN;
        end
        LEN: begin
          if (from_uart.data == 8'd0 || from_uart.data > 8'd8) begin
            reject      = 1'b1;
            reject_code = 2'd2;
            state_next  = IDLE;
          end else begin
            len_next      = from_uart.data[3:0];
            byte_cnt_next = 4'd0;
            xor_next      = xor_reg ^ from_uart.data;
            state_next    = PAYLOAD;
          end
        end
        PAYLOAD: begin
          shift_next    = {shift_reg[23:0], from_uart.data};
          xor_next      = xor_reg ^ from_uart.data;
          byte_cnt_next = cnt_inc;
          if (cnt_inc == len_reg) state_next = CHK;
        end
        CHK: begin
          state_next = IDLE;
          if (from_uart.data != xor_reg) begin
            reject      = 1'b1;
            reject_code = 2'd1;
          end else if (!cmd_ok) begin
            reject      = 1'b1;
            reject_code = 2'd2;
          end else begin
            commit = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      cmd_reg            <= 8'd0;
      len_reg            <= 4'd0;
      byte_cnt_reg       <= 4'd0;
      xor_reg            <= 8'd0;
      shift_reg          <= 32'd0;
      timeout_reg        <= '0;
      pattern_reg        <= DEFAULT_PATTERN;
      max_count_reg      <= DEFAULT_MAX_COUNT;
      tx_enable_reg      <= 1'b1;
      pattern_update_reg <= 1'b0;
      count_update_reg   <= 1'b0;
      frame_ok_reg       <= 1'b0;
      frame_err_reg      <= 1'b0;
      err_code_reg       <= 2'd0;
      err_count_reg      <= 8'd0;
    end else begin
      state_reg          <= state_next;
      cmd_reg            <= cmd_next;
      len_reg            <= len_next;
      byte_cnt_reg       <= byte_cnt_next;
      xor_reg            <= xor_next;
      shift_reg          <= shift_next;
      timeout_reg        <= timeout_next;
      frame_ok_reg       <= commit;
      frame_err_reg      <= reject;
      pattern_update_reg <= commit && (cmd_reg == 8'h01);
      count_update_reg   <= commit && (cmd_reg == 8'h02);
      if (commit && cmd_reg == 8'h01) pattern_reg   <= shift_reg;
      if (commit && cmd_reg == 8'h02) max_count_reg <= shift_reg;
      if (commit && cmd_reg == 8'h03) tx_enable_reg <= shift_reg[0];
      if (reject) begin
        err_code_reg <= reject_code;
        if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign pattern_data   = pattern_reg;
  assign pattern_update = pattern_update_reg;
  assign max_count      = max_count_reg;
  assign count_update   = count_update_reg;
  assign tx_enable      = tx_enable_reg;
  assign frame_ok       = frame_ok_reg;
  assign frame_err      = frame_err_reg;
  assign err_code       = err_code_reg;
  assign err_count      = err_count_reg;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed plus randomized frames checked against a byte-level frame model.
module tb_uart_frame_decoder;
  localparam int          TIMEOUT = 25000;
  localparam logic [31:0] DEF_PAT = 32'hA5A5_A5A5;
  localparam logic [31:0] DEF_MAX = 32'd9_000_000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pattern_data, max_count;
  logic        pattern_update, count_update, tx_enable, frame_ok, frame_err;
  logic [1:0]  err_code;
  logic [7:0]  err_count;

  always #20 clk = ~clk;

  uart_frame_decoder_if bus ();

  uart_frame_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .DEFAULT_PATTERN(DEF_PAT),
    .DEFAULT_MAX_COUNT(DEF_MAX)
  ) dut (
    .clk(clk),
    .rst(rst),
    .from_uart(bus),
    .pattern_data(pattern_data),
    .pattern_update(pattern_update),
    .max_count(max_count),
    .count_update(count_update),
    .tx_enable(tx_enable),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code),
    .err_count(err_count)
  );

  int errors = 0;
  int checks = 0;
  int frame_no = 0;

  logic [31:0] m_pat, m_max;
  logic        m_tx;
  logic [1:0]  m_code;
  int          m_cnt;
  logic [7:0]  fq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.data  = b;
    bus.valid = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.valid = 1'b0;
      bus.data  = 8'($urandom);
    end
  endtask

  task automatic model_reset();
    m_pat  = DEF_PAT;
    m_max  = DEF_MAX;
    m_tx   = 1'b1;
    m_code = 2'd0;
    m_cnt  = 0;
  endtask

  task automatic check_outputs(input string tag, input logic ok, input logic err,
                               input logic pu, input logic cu);
    chk({tag, ".frame_ok"},       frame_ok,       ok);
    chk({tag, ".frame_err"},      frame_err,      err);
    chk({tag, ".pattern_update"}, pattern_update, pu);
    chk({tag, ".count_update"},   count_update,   cu);
    chk({tag, ".pattern_data"},   pattern_data,   m_pat);
    chk({tag, ".max_count"},      max_count,      m_max);
    chk({tag, ".tx_enable"},      tx_enable,      m_tx);
    chk({tag, ".err_code"},       err_code,       m_code);
    chk({tag, ".err_count"},      err_count,      m_cnt);
  endtask

  // Expected outcome comes straight from the frame bytes: length range, XOR
  // checksum, then command/length agreement.
  task automatic send_frame(input string tag);
    int          cmd, ln, nsend;
    logic [7:0]  x, b;
    logic [31:0] val;
    logic        ok, err, pu, cu;
    ok = 0; err = 0; pu = 0; cu = 0;
    cmd = fq[1];
    ln  = fq[2];
    if (ln == 0 || ln > 8) begin
      err = 1; m_code = 2'd2; nsend = 3;
    end else begin
      nsend = ln + 4;
      x   = 8'(cmd ^ ln);
      val = 32'd0;
      for (int i = 0; i < ln; i++) begin
        x   = x ^ fq[3 + i];
        val = {val[23:0], fq[3 + i]};
      end
      if (fq[3 + ln] != x) begin
        err = 1; m_code = 2'd1;
      end else if (((cmd == 1 || cmd == 2) && ln == 4) || (cmd == 3 && ln == 1)) begin
        ok = 1;
        if (cmd == 1) begin m_pat = val; pu = 1; end
        if (cmd == 2) begin m_max = val; cu = 1; end
        if (cmd == 3) m_tx = fq[3][0];
      end else begin
        err = 1; m_code = 2'd2;
      end
    end
    if (err && m_cnt < 255) m_cnt++;

    repeat ($urandom_range(0, 2)) begin
      do b = 8'($urandom); while (b == 8'hA5);
      drive(b);
      idle($urandom_range(0, 1));
    end
    for (int i = 0; i < nsend; i++) begin
      drive(fq[i]);
      if (i != nsend - 1) idle($urandom_range(0, 2));
    end
    idle(1);
    frame_no++;
    $display("frame %0d %s: cmd=%02h len=%0d ok=%0b err=%0b code=%0d errcnt=%0d",
             frame_no, tag, cmd[7:0], ln, frame_ok, frame_err, err_code, err_count);
    check_outputs(tag, ok, err, pu, cu);
    idle(1);
    check_outputs({tag, ".after"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic gen_frame(input int kind);
    logic [7:0] cmd, ln, x, b;
    fq.delete();
    fq.push_back(8'hA5);
    case (kind)
      0: begin cmd = 8'h01; ln = 8'd4; end
      1: begin cmd = 8'h02; ln = 8'd4; end
      2: begin cmd = 8'h03; ln = 8'd1; end
      3: begin cmd = 8'($urandom_range(1, 3)); ln = (cmd == 8'h03) ? 8'd1 : 8'd4; end
      4: begin
        do begin
          cmd = 8'($urandom_range(0, 5));
          ln  = 8'($urandom_range(1, 8));
        end while (((cmd == 8'h01 || cmd == 8'h02) && ln == 8'd4) || (cmd == 8'h03 && ln == 8'd1));
      end
      default: begin
        cmd = 8'($urandom);
        ln  = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(9, 255));
      end
    endcase
    fq.push_back(cmd);
    fq.push_back(ln);
    if (kind <= 4) begin
      x = cmd ^ ln;
      for (int i = 0; i < int'(ln); i++) begin
        b = (kind == 2) ? 8'($urandom_range(0, 1)) : 8'($urandom);
        fq.push_back(b);
        x = x ^ b;
      end
      if (kind == 3) x = x ^ 8'($urandom_range(1, 255));
      fq.push_back(x);
    end
  endtask

  initial begin
    int waited;
    rst       = 1'b1;
    bus.valid = 1'b0;
    bus.data  = 8'h00;
    model_reset();
    idle(3);
    check_outputs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    fq = '{8'hA5, 8'h01, 8'h04, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0D};
    send_frame("pattern");
    chk("pattern_value", pattern_data, 32'h1234_5678);

    fq = '{8'hA5, 8'h03, 8'h01, 8'h00, 8'h02};
    send_frame("txen_off");
    chk("txen_off_value", tx_enable, 1'b0);
    fq = '{8'hA5, 8'h03, 8'h01, 8'h01, 8'h03};
    send_frame("txen_on");

    fq = '{8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h10, 8'h17};
    send_frame("bad_chk");
    chk("bad_chk_max", max_count, 32'd9_000_000);

    fq = '{8'hA5, 8'h01, 8'h02, 8'hAA, 8'hBB, 8'h12};
    send_frame("bad_len");
    fq = '{8'hA5, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00, 8'h10, 8'h16};
    send_frame("count");

    fq = '{8'hA5, 8'h01, 8'h09};
    send_frame("len_range");

    // Silence after A5 01: rejection must land TIMEOUT+2 sampling edges after the last byte.
    drive(8'hA5);
    drive(8'h01);
    waited = 0;
    for (int j = 1; j <= TIMEOUT + 100; j++) begin
      idle(1);
      if (frame_err === 1'b1) begin
        waited = j;
        break;
      end
    end
    chk("timeout_latency", waited, TIMEOUT + 2);
    m_code = 2'd3;
    if (m_cnt < 255) m_cnt++;
    $display("timeout after %0d cycles code=%0d", waited, err_code);
    check_outputs("timeout", 1'b0, 1'b1, 1'b0, 1'b0);
    gen_frame(0);
    send_frame("post_timeout");

    for (int k = 0; k < 300; k++) begin
      gen_frame($urandom_range(3, 5));
      send_frame("bad_rand");
    end
    chk("err_saturate", err_count, 8'd255);

    drive(8'hA5);
    drive(8'h01);
    drive(8'h04);
    drive(8'h12);
    @(negedge clk);
    rst       = 1'b1;
    bus.valid = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    idle(1);
    $display("mid-frame reset applied");
    check_outputs("mid_reset.after", 1'b0, 1'b0, 1'b0, 1'b0);
    gen_frame(1);
    send_frame("post_reset");

    for (int k = 0; k < 200; k++) begin
      gen_frame($urandom_range(0, 5));
      send_frame("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
